module_deco_gray_nbits_disp: RTL

Parametrised successor of the 4-bit Gray decoder top. Takes a WIDTH-bit Gray code from board switches, synchronises and debounces it, and converts it to binary (driven on LEDs). Shows the value on a DIGITS-digit multiplexed 7-segment display, in decimal or hexadecimal with leading-zero blanking. Display conversion uses a sequential double-dabble FSM.

---
 rtl/module_deco_gray_nbits_disp_if.sv | 24 ++
 rtl/module_deco_gray_nbits_disp.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/module_deco_gray_nbits_disp_if.sv
// Switch/LED/display bundle of the Gray decoder display block.
// master: drives the switch inputs and observes LEDs and display (board/bench side).
// slave : consumes switches, drives anodes, cathodes, LEDs and the update pulse (decoder side).
interface module_deco_gray_nbits_disp_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic [WIDTH-1:0]  codigo_gray_pi;     // Gray code from switches (asynchronous)
  logic              modo_hex_pi;        // 0 = decimal, 1 = hexadecimal (asynchronous)
  logic [DIGITS-1:0] anodo_po;           // active-low one-hot digit enable, bit 0 = LSD
  logic [6:0]        catodo_po;          // active-low segments {g,f,e,d,c,b,a}
  logic [WIDTH-1:0]  codigo_bin_led_po;  // binary value of the committed code
  logic              valido_po;          // one-cycle pulse on display update

  modport master (
    output codigo_gray_pi, modo_hex_pi,
    input  anodo_po, catodo_po, codigo_bin_led_po, valido_po
  );

  modport slave (
    input  codigo_gray_pi, modo_hex_pi,
    output anodo_po, catodo_po, codigo_bin_led_po, valido_po
  );
endinterface

// File: rtl/module_deco_gray_nbits_disp.sv
// Gray-to-binary decoder with debounced switch input and a multiplexed 7-segment display.
// Latency: commit 2+2^STABLE_W cycles after a stable input; display update WIDTH+2 (dec) / 2 (hex) after commit.
// Backpressure: none; commits arriving while a conversion runs are held until the FSM is idle.
// Ports: clk_pi clock, rst_pi async active-low reset, io (slave modport) switches in, LEDs/display out.
module module_deco_gray_nbits_disp #(
  parameter int WIDTH      = 8,
  parameter int DIGITS     = 3,
  parameter int SCAN_DIV_W = 6,
  parameter int STABLE_W   = 5
) (
  input logic                          clk_pi,
  input logic                          rst_pi,
  module_deco_gray_nbits_disp_if.slave io
);

  function automatic int dec_digits(input int w);
    longint v;
    int     n;
    v = (longint'(1) << w) - 1;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

  localparam int IN_W   = WIDTH + 1;  // {mode, gray}
  localparam int BCD_W  = DIGITS * 4;
  localparam int DD_W   = BCD_W + WIDTH;
  localparam int STEP_W = $clog2(WIDTH + 1);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  generate
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("WIDTH must be within 2..16");
    end
    if (DIGITS < dec_digits(WIDTH) || DIGITS * 4 < WIDTH) begin : g_bad_digits
      $error("DIGITS too small for WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] x);
    logic [DD_W-1:0] y;
    y = x;
    for (int i = 0; i < DIGITS; i++)
      if (y[WIDTH+4*i +: 4] >= 4'd5) y[WIDTH+4*i +: 4] = y[WIDTH+4*i +: 4] + 4'd3;
    return y << 1;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d, input logic blank);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  default: s = 7'b0001110;
    endcase
    return blank ? 7'b1111111 : s;
  endfunction

  logic [IN_W-1:0]              sync1_q, sync2_q, cand_q, committed_q;
  logic [STABLE_W-1:0]          stab_cnt_q;
  logic [WIDTH-1:0]             bin_q;
  state_t                       state_q, state_d;
  logic [DD_W-1:0]              dd_q;
  logic [STEP_W-1:0]            step_q;
  logic [DIGITS-1:0][3:0]       digit_q, digit_d;
  logic [DIGITS-1:0]            blank_q, blank_d;
  logic [SCAN_DIV_W-1:0]        scan_cnt_q;
  logic [IDX_W-1:0]             idx_q;
  logic [DIGITS-1:0]            anodo_q;
  logic [6:0]                   catodo_q;
  logic                         valido_q;
  logic                         commit;
  logic [BCD_W-1:0]             hex_ext;

  assign commit  = (stab_cnt_q == '1) && (cand_q != committed_q) && (state_q == IDLE);
  assign hex_ext = BCD_W'(bin_q);

  // Next-state logic; the committed mode bit picks the decimal or hex path.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit) state_d = cand_q[WIDTH] ? UPDATE : CONVERT;
      CONVERT: if (step_q == STEP_W'(WIDTH - 1)) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Digit values for the UPDATE load plus leading-zero blanking (digit 0 never blank).
  always_comb begin
    logic seen;
    digit_d = digit_q;
    blank_d = blank_q;
    seen    = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      digit_d[i] = committed_q[WIDTH] ? hex_ext[4*i +: 4] : dd_q[WIDTH+4*i +: 4];
      seen       = seen | (digit_d[i] != 4'd0);
      blank_d[i] = (i != 0) && !seen;
    end
  end

  always_ff @(posedge clk_pi or negedge rst_pi) begin
    if (!rst_pi) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      cand_q      <= '0;
      committed_q <= '0;
      stab_cnt_q  <= '0;
      bin_q       <= '0;
      state_q     <= IDLE;
      dd_q        <= '0;
      step_q      <= '0;
      digit_q     <= '0;
      blank_q     <= ~DIGITS'(1);
      valido_q    <= 1'b0;
    end else begin
      sync1_q  <= {io.modo_hex_pi, io.codigo_gray_pi};
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      valido_q <= (state_q == UPDATE);

      if (sync2_q != cand_q) begin
        cand_q     <= sync2_q;
        stab_cnt_q <= '0;
      end else if (stab_cnt_q != '1) begin
        stab_cnt_q <= stab_cnt_q + 1'b1;
      end

      // bin_q and the dabble register are both loaded straight from the
      // candidate so they are ready in the first cycle after the commit.
      if (commit) begin
        committed_q <= cand_q;
        bin_q       <= gray2bin(cand_q[WIDTH-1:0]);
        dd_q        <= {BCD_W'(0), gray2bin(cand_q[WIDTH-1:0])};
        step_q      <= '0;
      end else if (state_q == CONVERT) begin
        dd_q   <= dd_step(dd_q);
        step_q <= step_q + 1'b1;
      end

      if (state_q == UPDATE) begin
        digit_q <= digit_d;
        blank_q <= blank_d;
      end
    end
  end

  // Scan: anode and cathode are registered together from the same index.
  always_ff @(posedge clk_pi or negedge rst_pi) begin
    if (!rst_pi) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      anodo_q    <= ~DIGITS'(1);
      catodo_q   <= 7'b1000000;
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
      if (scan_cnt_q == '1)
        idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      anodo_q  <= ~(DIGITS'(1) << idx_q);
      catodo_q <= seg7(digit_q[idx_q], blank_q[idx_q]);
    end
  end

  assign io.anodo_po          = anodo_q;
  assign io.catodo_po         = catodo_q;
  assign io.codigo_bin_led_po = bin_q;
  assign io.valido_po         = valido_q;

endmodule
